// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader
//   Drain stage for the 16-bit circular FIFO. Pops words whenever the output
//   buffer has credit, tags them with sop/eop and presents fixed-length
//   packets on a valid/ready stream. A small circular skid buffer absorbs the
//   FIFO's one-cycle read latency, so back-pressure never loses data.
//
//   Optional feature macro: FIFO_PKT_READER_CHECKSUM_EN
//     When defined, each packet gets one extra trailing word holding the
//     modulo-2^DATA_W sum of its data words; eop moves onto that word.
//
// Ports
//   clk        : system clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_rd    : FIFO read strobe, one word popped per high cycle
//   fifo_dout  : FIFO read data, valid one cycle after fifo_rd
//   out_valid  : output word available (buffer not empty)
//   out_ready  : consumer accepts word
//   out_data   : output word (buffer head)
//   out_sop    : head word is first of packet
//   out_eop    : head word is last of packet
//   pkt_count  : completed packets, counts eop handshakes, wraps
module fifo_pkt_reader #(
   parameter int DATA_W    = 16,
   parameter int PKT_LEN   = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [15:0]       pkt_count
);

   localparam int              CW      = $clog2(BUF_DEPTH + 1);
   localparam int              PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(BUF_DEPTH);
   localparam logic [7:0]      LAST_W  = 8'(PKT_LEN - 1);
   localparam logic [PW-1:0]   LAST_P  = PW'(BUF_DEPTH - 1);

   logic [DATA_W-1:0]    buf_data [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] buf_sop;
   logic [BUF_DEPTH-1:0] buf_eop;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        buf_count;
   logic                 rd_pending;
   logic [7:0]           wcnt;
   logic [CW:0]          credit_used;
   logic                 has_credit;
   logic                 pop;
   logic                 push;
   logic [DATA_W-1:0]    push_data;
   logic                 push_sop;
   logic                 push_eop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + 1'b1;
   endfunction

   // Words already buffered plus the one in flight from the FIFO.
   assign credit_used = {1'b0, buf_count} + {{CW{1'b0}}, rd_pending};
   assign has_credit  = (credit_used < DEPTH_C);

   assign out_valid = (buf_count != '0);
   assign out_data  = buf_data[rd_ptr];
   assign out_sop   = buf_sop[rd_ptr];
   assign out_eop   = buf_eop[rd_ptr];
   assign pop       = out_valid && out_ready;

`ifdef FIFO_PKT_READER_CHECKSUM_EN
   localparam logic [0:0] ST_DATA = 1'b0;
   localparam logic [0:0] ST_CSUM = 1'b1;

   logic [0:0]        state;
   logic [DATA_W-1:0] acc;
   logic              csum_push;
   logic              last_in_flight;

   // The state only moves to CSUM when the last data word is captured, so the
   // read for the next packet is held back while that word is still in
   // flight; otherwise it would land ahead of the checksum word.
   assign last_in_flight = rd_pending && (wcnt == LAST_W);
   assign csum_push      = (state == ST_CSUM) && !rd_pending && has_credit;
   assign fifo_rd        = reset && !fifo_empty && (state == ST_DATA) &&
                           has_credit && !last_in_flight;

   always_comb begin
      push      = rd_pending || csum_push;
      push_data = rd_pending ? fifo_dout : acc;
      push_sop  = rd_pending && (wcnt == '0);
      push_eop  = !rd_pending;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_DATA;
         acc   <= '0;
      end else begin
         if (rd_pending)
            acc <= (wcnt == '0) ? fifo_dout : acc + fifo_dout;
         if (last_in_flight)
            state <= ST_CSUM;
         else if (csum_push)
            state <= ST_DATA;
      end
   end
`else
   // Gated by reset so the FIFO is never popped while the buffer is held clear.
   assign fifo_rd = reset && !fifo_empty && has_credit;

   always_comb begin
      push      = rd_pending;
      push_data = fifo_dout;
      push_sop  = (wcnt == '0);
      push_eop  = (wcnt == LAST_W);
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++)
            buf_data[i] <= '0;
         buf_sop    <= '0;
         buf_eop    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         buf_count  <= '0;
         rd_pending <= 1'b0;
         wcnt       <= '0;
         pkt_count  <= '0;
      end else begin
         rd_pending <= fifo_rd;
         if (push) begin
            buf_data[wr_ptr] <= push_data;
            buf_sop[wr_ptr]  <= push_sop;
            buf_eop[wr_ptr]  <= push_eop;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   buf_count <= buf_count + 1'b1;
            2'b01:   buf_count <= buf_count - 1'b1;
            default: buf_count <= buf_count;
         endcase
         if (rd_pending)
            wcnt <= (wcnt == LAST_W) ? '0 : wcnt + 1'b1;
         if (pop && out_eop)
            pkt_count <= pkt_count + 1'b1;
      end
   end

endmodule
